// File: rtl/cic_pkg.sv
// cic_pkg: shared constants for the 3-stage, R=32, M=2 CIC interpolator.
//   R, N, M   rate change, number of comb/integrator stages, differential delay
//   *_DEF     default widths for input, internal datapath and output
//   CNT_W     width of the low-rate phase counter (log2 R)
package cic_pkg;

  localparam int R = 32;
  localparam int N = 3;
  localparam int M = 2;

  localparam int W_IN_DEF  = 8;
  localparam int W_INT_DEF = 21;   // W_IN + log2((R*M)^N / R) = 8 + 13
  localparam int W_OUT_DEF = 10;

  localparam int CNT_W = 5;

endpackage

// File: rtl/cic_comb_m2.sv
// cic_comb_m2: one low-rate comb stage, y[k] = x[k] - x[k-DM], registered.
//   clk      system clock
//   reset_n  synchronous active-low reset, clears output and delay line
//   ld       low-rate clock enable; the stage only moves when ld is high
//   din      comb input (W bits, signed)
//   dout     registered comb output (W bits, signed)
// The output register adds one low-rate sample of latency per stage.
// Differences wrap modulo 2^W on purpose: the integrators downstream undo
// any wrap as long as the final result fits.
module cic_comb_m2 #(
  parameter int W  = 21,
  parameter int DM = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] dly [DM];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout <= '0;
      for (int k = 0; k < DM; k++) dly[k] <= '0;
    end else if (ld) begin
      dout   <= din - dly[DM-1];
      dly[0] <= din;
      for (int k = 1; k < DM; k++) dly[k] <= dly[k-1];
    end
  end

endmodule

// File: rtl/cic3i32.sv
// cic3i32: three-stage CIC interpolator, rate change 32, differential delay 2.
//   clk      system clock, all logic on its rising edge
//   reset_n  synchronous active-low reset; clears counter, combs, integrators
//   x_in     low-rate input sample (W_IN, signed); sampled on the clk edge
//            where clk2 is asserted
//   clk2     one-clk low-rate strobe to the upstream source, every 32 clocks
//   y_out    high-rate output (W_OUT, signed), top bits of the last integrator
// Datapath: input register -> 3 combs at the low rate -> zero-stuff by 32 ->
// 3 integrators at the full clock rate. DC gain into i2 is 8192, so y_out
// settles to 4*x for a constant input.
module cic3i32
  import cic_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_INT = W_INT_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [W_IN-1:0]  x_in,
  output logic                    clk2,
  output logic signed [W_OUT-1:0] y_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

  logic [CNT_W-1:0]        count;
  logic                    ld;
  logic signed [W_IN-1:0]  x;
  logic signed [W_INT-1:0] comb_v [N+1];
  logic signed [W_INT-1:0] u;
  logic signed [W_INT-1:0] i0, i1, i2;

  function automatic logic signed [W_INT-1:0] sxt(input logic signed [W_IN-1:0] v);
    return {{(W_INT - W_IN){v[W_IN-1]}}, v};
  endfunction

  assign ld = (count == LAST);

  // Low-rate phase: counter, strobe and input register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      clk2  <= 1'b0;
      x     <= '0;
    end else begin
      count <= count + CNT_W'(1);
      clk2  <= ld;
      if (ld) x <= x_in;
    end
  end

  // Comb section: the first comb sees the previously registered sample, so
  // every stage (including the input register) contributes one low-rate
  // sample of pipeline delay.
  assign comb_v[0] = sxt(x);

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_m2 #(
      .W  (W_INT),
      .DM (M)
    ) u_comb (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (ld),
      .din     (comb_v[g]),
      .dout    (comb_v[g+1])
    );
  end

  // Zero-stuff: the last comb updates on the ld edge, so count==0 is the
  // single cycle in which its fresh value is injected into the integrators.
  always_comb begin
    u = '0;
    if (count == '0) u = comb_v[N];
  end

  // Integrator section at the full rate; modulo-2^W_INT wrap is intended
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i0 <= '0;
      i1 <= '0;
      i2 <= '0;
    end else begin
      i0 <= i0 + u;
      i1 <= i1 + i0;
      i2 <= i2 + i1;
    end
  end

  // Output: truncation to the top bits, no rounding
  assign y_out = i2[W_INT-1 -: W_OUT];

endmodule
